// File: rtl/cbus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbus_arbiter_pkg
// Description : Policy and state encodings for the CBus arbiter, plus the
//               owner-index width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cbus_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_t;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int MAX_INPUTS = 8;

    // Width of an index into NUM_INPUTS masters (at least one bit).
    function automatic int arb_idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : cbus_arbiter_pkg
`default_nettype wire

// File: rtl/cbus_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cbus_types_pkg
// Description : Common CBus request/response types shared by all bus masters,
//               the arbiter and the memory-side bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package cbus_types_pkg;

    // Master-to-memory request; fields are held stable by the master from
    // valid until its final handshake.
    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [7:0]  len;       // beats minus one
    } cbus_req_t;

    // Memory-to-master response; last qualifies the final ready beat.
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage : cbus_types_pkg
`default_nettype wire

// File: rtl/cbus_arb_select.sv
`default_nettype none
// ============================================================================
// Module      : cbus_arb_select
// Description : Combinational winner selection. Fixed mode takes the lowest
//               valid index; round-robin mode takes the first valid index at
//               or after start_ptr, wrapping modulo NUM_INPUTS.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_arb_select
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int IDX_W      = arb_idx_w(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] valid,
    input  logic [IDX_W-1:0]      start_ptr,
    input  arb_mode_t             mode,
    output logic [IDX_W-1:0]      winner,
    output logic                  any_valid
);

    // Scan candidates in priority order and keep the first one that is valid.
    always_comb begin : p_pick
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        logic             found;
        winner   = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (mode == ARB_RR) begin
                cand = (int'(start_ptr) + k) % NUM_INPUTS;
            end else begin
                cand = k;
            end
            cand_idx = IDX_W'(cand);
            if (!found && valid[cand_idx]) begin
                winner = cand_idx;
                found  = 1'b1;
            end
        end
    end

    assign any_valid = |valid;

endmodule : cbus_arb_select
`default_nettype wire

// File: rtl/cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cbus_arbiter
// Description : N-way CBus arbiter. A registered grant is held for a whole
//               burst and released on the memory side's last ready beat;
//               the request/response data path through the owner is
//               combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module cbus_arbiter
    import cbus_types_pkg::*;
    import cbus_arbiter_pkg::*;
#(
    parameter int NUM_INPUTS = 2,
    parameter int ARB_MODE   = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  cbus_req_t             ireqs  [NUM_INPUTS],
    output cbus_resp_t            iresps [NUM_INPUTS],
    output cbus_req_t             oreq,
    input  cbus_resp_t            oresp,
    output logic [NUM_INPUTS-1:0] grant,
    output logic                  busy
);

    localparam int        IDX_W = arb_idx_w(NUM_INPUTS);
    localparam arb_mode_t MODE  = (ARB_MODE == 0) ? ARB_FIXED : ARB_RR;

    if (NUM_INPUTS < 2 || NUM_INPUTS > MAX_INPUTS) begin : g_bad_num_inputs
        $error("cbus_arbiter: NUM_INPUTS must be in 2..8");
    end

    arb_state_t            state;
    logic [IDX_W-1:0]      owner;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      winner;
    logic [IDX_W-1:0]      next_ptr;
    logic                  any_valid;
    logic                  release_beat;
    logic [NUM_INPUTS-1:0] req_valid;
    logic [NUM_INPUTS-1:0] winner_onehot;

    // Gather the per-master valid bits into a vector for the selector.
    always_comb begin
        req_valid = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            req_valid[i] = ireqs[i].valid;
        end
    end

    cbus_arb_select #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_W      (IDX_W)
    ) u_select (
        .valid      (req_valid),
        .start_ptr  (rr_ptr),
        .mode       (MODE),
        .winner     (winner),
        .any_valid  (any_valid)
    );

    assign winner_onehot = {{(NUM_INPUTS-1){1'b0}}, 1'b1} << winner;
    assign next_ptr      = (owner == IDX_W'(NUM_INPUTS - 1)) ? '0 : owner + 1'b1;
    assign release_beat  = oresp.ready && oresp.last;

    // Ownership FSM: latch a winner from IDLE, hold it until the last beat.
    // An owner dropping valid mid-burst does not release the bus.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= ARB_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            grant  <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (any_valid) begin
                        state <= ARB_BUSY;
                        owner <= winner;
                        grant <= winner_onehot;
                        busy  <= 1'b1;
                    end
                end
                ARB_BUSY: begin
                    if (release_beat) begin
                        state <= ARB_IDLE;
                        grant <= '0;
                        busy  <= 1'b0;
                        if (MODE == ARB_RR) begin
                            rr_ptr <= next_ptr;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Route the owner's request out and the memory response back to it only;
    // everything is zero while idle.
    always_comb begin
        oreq = '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
            iresps[j] = '0;
        end
        if (state == ARB_BUSY) begin
            oreq          = ireqs[owner];
            iresps[owner] = oresp;
        end
    end

endmodule : cbus_arbiter
`default_nettype wire

// File: tb/tb_cbus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbus_arbiter
// Description : Randomized self-checking bench. Three arbiter configurations
//               (2-way round-robin, 4-way fixed, 4-way round-robin) run side
//               by side, each against a cycle-level reference model of the
//               ownership rules, with random bursts, owner drops and
//               mid-burst resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbus_arbiter;
    import cbus_types_pkg::*;
    import cbus_arbiter_pkg::*;

    localparam int NCYC = 2500;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    for (genvar c = 0; c < 3; c++) begin : g_cfg
        localparam int N    = (c == 0) ? 2 : 4;
        localparam int MODE = (c == 1) ? 0 : 1;

        cbus_req_t      ireqs  [N];
        cbus_resp_t     iresps [N];
        cbus_req_t      oreq;
        cbus_resp_t     oresp;
        logic [N-1:0]   grant;
        logic           busy;
        logic           rstn;

        cbus_arbiter #(
            .NUM_INPUTS (N),
            .ARB_MODE   (MODE)
        ) u_dut (
            .clk    (clk),
            .resetn (rstn),
            .ireqs  (ireqs),
            .iresps (iresps),
            .oreq   (oreq),
            .oresp  (oresp),
            .grant  (grant),
            .busy   (busy)
        );

        initial begin : p_run
            int          m_owner;   // -1 when idle
            int          m_next;    // round-robin search start
            int          m_beats;   // ready beats delivered in current burst
            int          best;
            int          bestd;
            int          d;
            bit          in_rst;
            bit          pend  [N];
            bit          drop  [N];
            int          plen  [N];
            logic [31:0] paddr [N];
            logic [31:0] pdata [N];
            logic [N-1:0] eg;
            cbus_req_t   ereq;
            cbus_resp_t  eresp;

            m_owner = -1;
            m_next  = 0;
            m_beats = 0;
            in_rst  = 1'b0;
            for (int i = 0; i < N; i++) begin
                pend[i]  = 1'b0;
                drop[i]  = 1'b0;
                plen[i]  = 0;
                paddr[i] = '0;
                pdata[i] = '0;
                ireqs[i] = '0;
            end
            oresp = '0;
            rstn  = 1'b0;
            repeat (3) @(posedge clk);
            #1 rstn = 1'b1;

            for (int cyc = 0; cyc < NCYC; cyc++) begin
                @(posedge clk);
                #1;
                // Advance the model over the edge just taken.
                if (in_rst) begin
                    rstn   = 1'b1;
                    in_rst = 1'b0;
                end else if (m_owner < 0) begin
                    best  = -1;
                    bestd = N + 1;
                    for (int i = 0; i < N; i++) begin
                        if (ireqs[i].valid) begin
                            d = (MODE == 1) ? ((i - m_next + N) % N) : i;
                            if (d < bestd) begin
                                bestd = d;
                                best  = i;
                            end
                        end
                    end
                    if (best >= 0) begin
                        m_owner = best;
                        m_beats = 0;
                    end
                end else if (oresp.ready && oresp.last) begin
                    pend[m_owner] = 1'b0;
                    drop[m_owner] = 1'b0;
                    if (MODE == 1) m_next = (m_owner + 1) % N;
                    m_owner = -1;
                end else if (oresp.ready) begin
                    m_beats++;
                end

                // New master activity for this cycle.
                for (int i = 0; i < N; i++) begin
                    if (!pend[i] && cyc > 12 && ($urandom % 3 == 0)) begin
                        pend[i]  = 1'b1;
                        plen[i]  = ($urandom % 8 == 0) ? 7 : int'($urandom % 4);
                        paddr[i] = $urandom;
                        pdata[i] = $urandom;
                    end
                end
                if (m_owner >= 0 && m_beats > 0 && !drop[m_owner] && ($urandom % 10 == 0))
                    drop[m_owner] = 1'b1;
                for (int i = 0; i < N; i++) begin
                    ireqs[i].valid    = pend[i] && !drop[i];
                    ireqs[i].is_write = paddr[i][0];
                    ireqs[i].size     = paddr[i][3:1];
                    ireqs[i].addr     = paddr[i];
                    ireqs[i].strb     = pdata[i][3:0];
                    ireqs[i].data     = pdata[i];
                    ireqs[i].len      = plen[i][7:0];
                end
                oresp.ready = ($urandom % 4) != 0;
                oresp.data  = $urandom;
                if (m_owner >= 0)
                    oresp.last = oresp.ready && (m_beats == plen[m_owner]);
                else
                    oresp.last = 1'($urandom % 2);
                #1;

                // Expected outputs for this cycle.
                eg   = '0;
                ereq = '0;
                if (m_owner >= 0) begin
                    eg[m_owner] = 1'b1;
                    ereq        = ireqs[m_owner];
                end
                check_eq($sformatf("c%0d_busy cyc%0d", c, cyc), busy, (m_owner >= 0));
                check_eq($sformatf("c%0d_grant cyc%0d", c, cyc), grant, eg);
                check_eq($sformatf("c%0d_oreq cyc%0d", c, cyc), oreq, ereq);
                for (int j = 0; j < N; j++) begin
                    eresp = (j == m_owner) ? oresp : '0;
                    check_eq($sformatf("c%0d_iresp%0d cyc%0d", c, j, cyc), iresps[j], eresp);
                end

                // Occasionally pull reset during the third beat of a burst.
                if (m_owner >= 0 && m_beats == 2 && ($urandom % 6 == 0)) begin
                    rstn = 1'b0;
                    #1;
                    check_eq($sformatf("c%0d_rst_busy cyc%0d", c, cyc), busy, 1'b0);
                    check_eq($sformatf("c%0d_rst_grant cyc%0d", c, cyc), grant, '0);
                    check_eq($sformatf("c%0d_rst_oreq cyc%0d", c, cyc), oreq, '0);
                    check_eq($sformatf("c%0d_rst_iresp cyc%0d", c, cyc), iresps[m_owner], '0);
                    m_owner = -1;
                    m_next  = 0;
                    for (int i = 0; i < N; i++) drop[i] = 1'b0;
                    in_rst = 1'b1;
                end
            end
            n_done++;
        end
    end

    initial begin : p_summary
        repeat (NCYC + 40) @(posedge clk);
        check_eq("runs_done", n_done, 3);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_cbus_arbiter
`default_nettype wire
